// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and line/word helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned LINES   = 8;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned TAG_W   = 25;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = WORDS * WORD_W;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_LSB = 0;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned TAG_LSB = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{off, 5'd0} +: WORD_W] = word;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read of one index, one whole-entry write per cycle.
module dcache_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              dirty_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // Status bits: reset clears every line, a write always leaves the entry valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {LINES{1'b0}};
            dirty_q <= {LINES{1'b0}};
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= dirty_i;
        end else begin
            valid_q <= valid_q;
            dirty_q <= dirty_q;
        end
    end

    // Tag and data payload carry no reset; an invalid line is never consumed.
    always_ff @(posedge clk) begin
        if (we_i && !rst) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller (IDLE/WRITEBACK/ALLOCATE FSM).
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [29:0]   proc_addr,
    input  logic [31:0]   proc_wdata,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [27:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);

    state_e state_q, state_d;

    logic [OFF_W-1:0]  off_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              req_s;
    logic              hit_s;
    logic              stall_s;
    logic              rd_valid_s;
    logic              rd_dirty_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [LINE_W-1:0] rd_line_s;
    logic              arr_we_s;
    logic [LINE_W-1:0] arr_line_s;
    logic              arr_dirty_s;

    assign off_s = proc_addr[OFF_LSB +: OFF_W];
    assign idx_s = proc_addr[IDX_LSB +: IDX_W];
    assign tag_s = proc_addr[TAG_LSB +: TAG_W];
    assign req_s = proc_read | proc_write;
    assign hit_s = (state_q == IDLE) && req_s && rd_valid_s && (rd_tag_s == tag_s);

    dcache_array u_array (
        .clk     (clk),
        .rst     (rst),
        .idx_i   (idx_s),
        .we_i    (arr_we_s),
        .tag_i   (tag_s),
        .line_i  (arr_line_s),
        .dirty_i (arr_dirty_s),
        .valid_o (rd_valid_s),
        .dirty_o (rd_dirty_s),
        .tag_o   (rd_tag_s),
        .line_o  (rd_line_s)
    );

    // State register; reset wins even in the middle of a memory transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory request and array write control.
    always_comb begin
        state_d     = state_q;
        stall_s     = 1'b0;
        proc_rdata  = 32'd0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = 28'd0;
        mem_wdata   = 128'd0;
        arr_we_s    = 1'b0;
        arr_line_s  = rd_line_s;
        arr_dirty_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    // A simultaneous read and write is serviced as a write.
                    if (proc_write) begin
                        arr_we_s    = 1'b1;
                        arr_line_s  = put_word(rd_line_s, off_s, proc_wdata);
                        arr_dirty_s = 1'b1;
                    end else begin
                        proc_rdata = get_word(rd_line_s, off_s);
                    end
                end else if (req_s) begin
                    stall_s = 1'b1;
                    state_d = (rd_valid_s && rd_dirty_s) ? WRITEBACK : ALLOCATE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                stall_s   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {rd_tag_s, idx_s};
                mem_wdata = rd_line_s;
                if (mem_ready) begin
                    state_d = ALLOCATE;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                stall_s  = 1'b1;
                mem_read = 1'b1;
                mem_addr = proc_addr[29:2];
                if (mem_ready) begin
                    arr_we_s   = 1'b1;
                    arr_line_s = mem_rdata;
                    state_d    = IDLE;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With reset held and nothing requested the processor must see no stall.
    assign proc_stall = stall_s & (req_s | ~rst);

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expectations, monitor and memory model check.
module tb_dcache_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          proc_read = 1'b0;
    logic          proc_write = 1'b0;
    logic [29:0]   proc_addr = 30'd0;
    logic [31:0]   proc_wdata = 32'd0;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata = 128'd0;
    logic          mem_ready = 1'b0;

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [31:0] data; int stalls; } proc_exp_t;
    typedef struct { logic wr; logic [27:0] addr; logic [127:0] data; } mem_exp_t;

    proc_exp_t proc_q[$];
    mem_exp_t  mem_q[$];

    int total = 0;
    int bad = 0;
    int mem_delay = 0;

    localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002;
    localparam logic [31:0] WC = 32'hC0C0_0003, WD = 32'hD0D0_0004;
    localparam logic [31:0] WE = 32'hE0E0_0005, WF = 32'hF0F0_0006;
    localparam logic [31:0] WG = 32'h1111_0007, WH = 32'h2222_0008;
    localparam logic [127:0] LINE0 = {WD, WC, WB, WA};
    localparam logic [127:0] LINE1 = {WH, WG, WF, WE};
    localparam logic [127:0] LINE2 = 128'h3333_3333_4444_4444_5555_5555_6666_6666;
    localparam logic [127:0] LINE3 = 128'h7777_7777_8888_8888_9999_9999_ABCD_0123;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Processor-side monitor: counts stall cycles and checks each serviced request.
    int        stall_cnt = 0;
    proc_exp_t pe;
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else if (proc_read || proc_write) begin
            if (proc_stall) begin
                stall_cnt++;
            end else begin
                if (proc_q.size() == 0) begin
                    chk("unexpected_service", 128'd1, 128'd0);
                end else begin
                    pe = proc_q.pop_front();
                    chk("stall_cycles", 128'(stall_cnt), 128'(pe.stalls));
                    if (!pe.wr) chk("proc_rdata", {96'd0, proc_rdata}, {96'd0, pe.data});
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Memory model: checks each request against the queue, holds it for mem_delay, then readies.
    mem_exp_t     cur;
    logic         mem_busy = 1'b0;
    int           mem_cnt = 0;
    logic [27:0]  cur_addr;
    logic [127:0] cur_wdata;
    always @(negedge clk) begin
        if (rst) begin
            mem_busy  = 1'b0;
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_busy  = 1'b0;
                chk("req_drop", {127'd0, cur.wr ? mem_write : mem_read}, 128'd0);
            end
            if (mem_read || mem_write) begin
                if (!mem_busy) begin
                    chk("rd_wr_exclusive", {127'd0, mem_read & mem_write}, 128'd0);
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", 128'd1, 128'd0);
                        cur = '{1'b0, 28'd0, 128'd0};
                    end else begin
                        cur = mem_q.pop_front();
                        chk("mem_kind", {127'd0, mem_write}, {127'd0, cur.wr});
                        chk("mem_addr", {100'd0, mem_addr}, {100'd0, cur.addr});
                        if (cur.wr) chk("mem_wdata", mem_wdata, cur.data);
                    end
                    mem_busy  = 1'b1;
                    mem_cnt   = 0;
                    cur_addr  = mem_addr;
                    cur_wdata = mem_wdata;
                end else begin
                    chk("addr_stable", {100'd0, mem_addr}, {100'd0, cur_addr});
                    if (cur.wr) chk("wdata_stable", mem_wdata, cur_wdata);
                end
                if (mem_cnt == mem_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.wr ? 128'd0 : cur.data;
                end
                mem_cnt++;
            end
        end
    end

    // Drives a request from just after a rising edge and holds it until the cycle it is serviced.
    task automatic issue(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
        int   n;
        logic done;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            done = !proc_stall;
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_timeout", {127'd0, done}, 128'd1);
    endtask

    task automatic idle(input int cycles);
        proc_read  = 1'b0;
        proc_write = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        // Reset with no request: quiet processor and memory sides.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {127'd0, proc_stall}, 128'd0);
        chk("rst_rdata", {96'd0, proc_rdata}, 128'd0);
        chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read of 0x10: clean fill of line address 0x4.
        mem_delay = 2;
        mem_q.push_back('{1'b0, 28'h0000004, LINE0});
        proc_q.push_back('{1'b0, WA, 4});
        issue(1'b1, 1'b0, 30'h0000010, 32'd0);

        // Back-to-back zero-wait hits across the line.
        proc_q.push_back('{1'b0, WA, 0});
        proc_q.push_back('{1'b0, WB, 0});
        proc_q.push_back('{1'b0, WC, 0});
        proc_q.push_back('{1'b0, WD, 0});
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 30'h0000010 + 30'(i), 32'd0);

        // Write hit then read back; line becomes dirty.
        proc_q.push_back('{1'b1, 32'd0, 0});
        issue(1'b0, 1'b1, 30'h0000011, 32'hDEADBEEF);
        proc_q.push_back('{1'b0, 32'hDEADBEEF, 0});
        issue(1'b1, 1'b0, 30'h0000011, 32'd0);
        idle(1);
        chk("dirty4", {127'd0, dut.u_array.dirty_q[4]}, 128'd1);

        // Dirty eviction on slow memory: writeback 0x4 then fill 0x24.
        mem_delay = 10;
        mem_q.push_back('{1'b1, 28'h0000004, {WD, WC, 32'hDEADBEEF, WA}});
        mem_q.push_back('{1'b0, 28'h0000024, LINE1});
        proc_q.push_back('{1'b0, WF, 23});
        issue(1'b1, 1'b0, 30'h0000091, 32'd0);
        proc_q.push_back('{1'b0, WG, 0});
        issue(1'b1, 1'b0, 30'h0000092, 32'd0);

        // Write miss allocates, then read/write collision is treated as a write.
        mem_delay = 2;
        mem_q.push_back('{1'b0, 28'h0000009, LINE2});
        proc_q.push_back('{1'b1, 32'd0, 4});
        issue(1'b0, 1'b1, 30'h0000025, 32'h0BAD_F00D);
        proc_q.push_back('{1'b0, 32'h0BAD_F00D, 0});
        issue(1'b1, 1'b0, 30'h0000025, 32'd0);
        proc_q.push_back('{1'b0, LINE2[31:0], 0});
        issue(1'b1, 1'b0, 30'h0000024, 32'd0);
        proc_q.push_back('{1'b1, 32'd0, 0});
        issue(1'b1, 1'b1, 30'h0000026, 32'h1234_5678);
        proc_q.push_back('{1'b0, 32'h1234_5678, 0});
        issue(1'b1, 1'b0, 30'h0000026, 32'd0);
        idle(1);

        // Reset while a fill is outstanding.
        mem_delay = 20;
        mem_q.push_back('{1'b0, 28'h0000010, LINE3});
        proc_read = 1'b1;
        proc_addr = 30'h0000040;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("abort_mem_read", {127'd0, seen}, 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_read", {127'd0, mem_read}, 128'd0);
        chk("post_rst_mem_write", {127'd0, mem_write}, 128'd0);
        chk("post_rst_stall", {127'd0, proc_stall}, 128'd0);
        @(posedge clk);
        #1;

        // Everything was invalidated: both re-reads miss and refill without writeback.
        mem_delay = 1;
        mem_q.push_back('{1'b0, 28'h0000010, LINE3});
        proc_q.push_back('{1'b0, LINE3[31:0], 3});
        issue(1'b1, 1'b0, 30'h0000040, 32'd0);
        mem_q.push_back('{1'b0, 28'h0000024, LINE1});
        proc_q.push_back('{1'b0, WG, 3});
        issue(1'b1, 1'b0, 30'h0000092, 32'd0);
        idle(3);

        chk("proc_q_drained", 128'(proc_q.size()), 128'd0);
        chk("mem_q_drained", 128'(mem_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL provide port proc_read, input, 1 bit: processor read request.
REQ-004 SHALL provide port proc_write, input, 1 bit: processor write request.
REQ-005 SHALL provide port proc_addr, input, 30 bits: processor word address.
REQ-006 SHALL provide port proc_wdata, input, 32 bits: processor write data.
REQ-007 SHALL provide port proc_rdata, output, 32 bits: read data, valid when proc_read=1 and proc_stall=0.
REQ-008 SHALL provide port proc_stall, output, 1 bit: request not yet serviced; processor holds its request stable.
REQ-009 SHALL provide port mem_read, output, 1 bit: memory line-fill request.
REQ-010 SHALL provide port mem_write, output, 1 bit: memory line-writeback request.
REQ-011 SHALL provide port mem_addr, output, 28 bits: memory line address.
REQ-012 SHALL provide port mem_wdata, output, 128 bits: writeback line, word 0 in bits [31:0].
REQ-013 SHALL provide port mem_rdata, input, 128 bits: fill line, word 0 in bits [31:0].
REQ-014 SHALL provide port mem_ready, input, 1 bit: memory completed the current read or write.

Function
REQ-015 SHALL be direct-mapped, write-back and write-allocate: 8 lines of 4 words, with a valid bit, a dirty bit and a 25-bit tag per line.
REQ-016 SHALL split proc_addr into offset [1:0], index [4:2] and tag [29:5]; the line address SHALL be proc_addr[29:2].
REQ-017 SHALL implement states IDLE, WRITEBACK and ALLOCATE.
REQ-018 SHALL define hit as (proc_read|proc_write) and valid[index] and tag[index]==tag, evaluated in IDLE only.
REQ-019 SHALL, on a read hit, drive proc_stall=0 and the selected word combinationally on proc_rdata in the same cycle (zero-wait).
REQ-020 SHALL, on a write hit, drive proc_stall=0 and at the clock edge write proc_wdata into the selected word and set dirty.
REQ-021 SHALL, in IDLE on a miss, assert proc_stall combinationally; next state is WRITEBACK if valid&dirty, else ALLOCATE.
REQ-022 SHALL, in WRITEBACK, drive mem_write=1, mem_addr={stored tag,index} and mem_wdata=line; on mem_ready go to ALLOCATE.
REQ-023 SHALL, in ALLOCATE, drive mem_read=1 and mem_addr=proc_addr[29:2]; on mem_ready load mem_rdata, set valid=1, dirty=0 and return to IDLE.
REQ-024 SHALL keep proc_stall=1 in WRITEBACK and ALLOCATE; the retried request then hits in IDLE, so a miss costs at least 1 cycle beyond memory latency.
REQ-025 SHALL hold mem_read, mem_write, mem_addr and mem_wdata stable until mem_ready, and deassert the request in the cycle after mem_ready.
REQ-026 SHALL never assert mem_read and mem_write simultaneously.
REQ-027 SHALL ignore mem_ready in IDLE.
REQ-028 SHALL treat proc_read&proc_write both high as a write.
REQ-029 SHALL, with no request, keep proc_stall=0, hold state, and leave the arrays unchanged.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, go to IDLE and clear all valid and dirty bits, even mid-WRITEBACK or mid-ALLOCATE.
REQ-031 SHALL drive mem_read=0 and mem_write=0 from the cycle after reset; tag and data arrays need not be reset.
REQ-032 SHALL hold proc_stall=0 and proc_rdata=0 while reset is active with no request.

Structure
REQ-033 SHALL define the following in shared package dcache_pkg: line count 8, words per line 4, tag width 25, the state enum (IDLE/WRITEBACK/ALLOCATE) and field-slice constants.
REQ-034 SHALL place tag, valid, dirty and data storage in a sub-module dcache_array (combinational read, single synchronous write port); the FSM stays in dcache_ctrl.

Verification
REQ-035 SHALL verify a cold read: read 0x0000010 -> stall, mem_read with mem_addr=0x0000004; after mem_ready with line {D,C,B,A}, the next cycle gives proc_rdata=A and stall=0.
REQ-036 SHALL verify a write hit then read: write 0x0000011 with 0xDEADBEEF after the fill -> zero stall; a read of 0x0000011 returns 0xDEADBEEF and dirty[4]=1.
REQ-037 SHALL verify a dirty eviction: read 0x0000091 (same index 4, different tag) -> mem_write at 0x0000004 with word1=0xDEADBEEF, then mem_read at 0x0000024, then hit.
REQ-038 SHALL verify slow memory: mem_ready delayed 10 cycles -> mem_addr and mem_wdata stable throughout, and the request deasserted 1 cycle after mem_ready.
REQ-039 SHALL verify reset mid-ALLOCATE: rst pulsed -> IDLE, mem_read=0 next cycle, and a re-read of the same address misses again.
REQ-040 SHALL verify back-to-back hits: 4 reads of 0x10..0x13 on consecutive cycles -> 4 zero-stall results A, B, C, D.
